// File: rtl/hub75_rx_if.sv
// rtl/hub75_rx_if.sv - pixel stream interface of the HUB75 panel-side receiver
interface hub75_rx_if #(
  parameter int COLS = 32
);
  localparam int CW = $clog2(COLS);

  logic          valid;
  logic          ready;
  logic [5:0]    rgb;
  logic [CW-1:0] col;
  logic [3:0]    row;
  logic          last;

  modport master (output valid, rgb, col, row, last, input ready);
  modport slave  (input valid, rgb, col, row, last, output ready);
endinterface

// File: rtl/hub75_rx.sv
// rtl/hub75_rx.sv - HUB75 receiver: oversampled deserialiser, ping-pong row buffer, pixel streamer
module hub75_rx #(
  parameter int COLS        = 32,
  parameter int ON_W        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r0,
  input  logic            g0,
  input  logic            b0,
  input  logic            r1,
  input  logic            g1,
  input  logic            b1,
  input  logic            ra,
  input  logic            rb,
  input  logic            rc,
  input  logic            rd,
  input  logic            hub_clk,
  input  logic            latch,
  input  logic            oe,
  hub75_rx_if.master      pix,
  output logic [ON_W-1:0] on_time,
  output logic            ovf,
  output logic            len_err
);
  localparam int CW  = $clog2(COLS);
  localparam int NIN = 13;
  // OE idles high so the on-time counter stays still while the chain fills
  localparam logic [NIN-1:0]  IN_IDLE  = 13'h1000;
  localparam logic [CW+1:0]   CNT_FULL = (CW+2)'(COLS);
  localparam logic [CW+1:0]   CNT_SAT  = (CW+2)'(2 * COLS);
  localparam logic [CW-1:0]   COL_LAST = CW'(COLS - 1);
  localparam logic [ON_W-1:0] ON_MAX   = '1;

  typedef enum logic {IDLE, STREAM} state_t;

  logic [1:0]     rst_q;
  logic           rst_i_n;
  logic [NIN-1:0] pins;
  logic [NIN-1:0] sync_q [SYNC_STAGES];
  logic [NIN-1:0] cur;
  logic [1:0]     prv;
  logic           shift_rise;
  logic           latch_rise;
  logic [5:0]     din;
  logic [5:0]     mem [2*COLS];

  state_t         state;
  logic           wsel;
  logic [CW+1:0]  shift_cnt;
  logic [CW+1:0]  cnt_eff;
  logic           shift_cnt_inc;
  logic           shift_take;
  logic [CW-1:0]  wr_col;
  logic [ON_W-1:0] on_cnt;
  logic           valid_q;
  logic           last_q;
  logic [5:0]     rgb_q;
  logic [CW-1:0]  col_q;
  logic [CW-1:0]  col_nxt;
  logic [3:0]     row_q;
  logic [5:0]     first_rgb;
  logic           start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_i_n = rst_q[1];

  assign pins = {oe, latch, hub_clk, rd, rc, rb, ra, b1, g1, r1, b0, g0, r0};

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IN_IDLE;
      prv <= 2'b00;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prv <= sync_q[SYNC_STAGES-1][11:10];
    end
  end

  assign cur        = sync_q[SYNC_STAGES-1];
  assign shift_rise = cur[10] & ~prv[0];
  assign latch_rise = cur[11] & ~prv[1];
  assign din        = {cur[3], cur[4], cur[5], cur[0], cur[1], cur[2]};

  // A shift coinciding with a latch still belongs to the row being latched
  assign shift_cnt_inc = shift_rise && (shift_cnt != CNT_SAT);
  assign cnt_eff       = shift_cnt + {{(CW+1){1'b0}}, shift_cnt_inc};
  assign shift_take    = shift_rise && (shift_cnt < CNT_FULL);
  assign wr_col        = COL_LAST - shift_cnt[CW-1:0];

  always_ff @(posedge clk) begin
    if (shift_take) mem[{wsel, wr_col}] <= din;
  end

  // Column 0 may be written in the very cycle the buffer flips to the read side
  assign first_rgb = (shift_take && (wr_col == '0)) ? din : mem[{wsel, {CW{1'b0}}}];
  assign col_nxt   = col_q + CW'(1);
  assign start     = latch_rise && ((state == IDLE) || (pix.ready && last_q));

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state     <= IDLE;
      wsel      <= 1'b0;
      shift_cnt <= '0;
      on_cnt    <= '0;
      on_time   <= '0;
      ovf       <= 1'b0;
      len_err   <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      rgb_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      ovf     <= latch_rise && !start;
      len_err <= 1'b0;
      if (latch_rise) begin
        shift_cnt <= '0;
        on_time   <= on_cnt;
        on_cnt    <= '0;
        len_err   <= (cnt_eff != CNT_FULL);
      end else begin
        if (shift_cnt_inc) shift_cnt <= shift_cnt + (CW+2)'(1);
        if (!cur[12] && (on_cnt != ON_MAX)) on_cnt <= on_cnt + ON_W'(1);
      end

      if (start) begin
        state   <= STREAM;
        wsel    <= ~wsel;
        valid_q <= 1'b1;
        last_q  <= 1'b0;
        col_q   <= '0;
        row_q   <= cur[9:6];
        rgb_q   <= first_rgb;
      end else if ((state == STREAM) && pix.ready) begin
        if (last_q) begin
          state   <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          col_q   <= '0;
          rgb_q   <= '0;
        end else begin
          col_q   <= col_nxt;
          last_q  <= (col_nxt == COL_LAST);
          rgb_q   <= mem[{~wsel, col_nxt}];
        end
      end
    end
  end

  assign pix.valid = valid_q;
  assign pix.rgb   = rgb_q;
  assign pix.col   = col_q;
  assign pix.row   = row_q;
  assign pix.last  = last_q;
endmodule

// File: tb/tb_hub75_rx.sv
// tb/tb_hub75_rx.sv - randomized directed bench for hub75_rx against a row-buffer reference model
module tb_hub75_rx;
  localparam int COLS = 32;
  localparam int CW   = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic r0, g0, b0, r1, g1, b1, ra, rb, rc, rd, hub_clk, latch, oe;
  logic ready_fix, rnd_en;
  logic rnd_bit = 1'b1;
  logic [15:0] on_time;
  logic [7:0]  on_time8;
  logic ovf, len_err, ovf8, len_err8;

  hub75_rx_if #(.COLS(COLS)) pif  ();
  hub75_rx_if #(.COLS(COLS)) pif8 ();
  assign pif.ready  = rnd_en ? rnd_bit : ready_fix;
  assign pif8.ready = pif.ready;

  always #5 clk = ~clk;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(1, 0));

  hub75_rx #(.COLS(COLS), .ON_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .ra(ra), .rb(rb), .rc(rc), .rd(rd), .hub_clk(hub_clk), .latch(latch), .oe(oe),
    .pix(pif), .on_time(on_time), .ovf(ovf), .len_err(len_err));

  hub75_rx #(.COLS(COLS), .ON_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .ra(ra), .rb(rb), .rc(rc), .rd(rd), .hub_clk(hub_clk), .latch(latch), .oe(oe),
    .pix(pif8), .on_time(on_time8), .ovf(ovf8), .len_err(len_err8));

  // Stream observer
  logic [15:0] beat_mem [2048];
  int beat_n = 0, ovf_seen = 0, len_seen = 0, ovf8_seen = 0, len8_seen = 0;
  int valid_cyc = 0, stall_viol = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [15:0] pb = '0;
  logic [15:0] cur_beat;
  assign cur_beat = {pif.rgb, pif.col, pif.row, pif.last};

  always @(negedge clk) begin
    if (pif.valid && pif.ready && beat_n < 2048) begin
      beat_mem[beat_n] = cur_beat;
      beat_n++;
    end
    if (ovf)      ovf_seen++;
    if (len_err)  len_seen++;
    if (ovf8)     ovf8_seen++;
    if (len_err8) len8_seen++;
    if (pif.valid) valid_cyc++;
    if (pv && !pr && (!pif.valid || cur_beat != pb)) stall_viol++;
    pv = pif.valid;
    pr = pif.ready;
    pb = cur_beat;
  end

  // Reference model: two line buffers, a write index, a shift count
  logic [5:0] bufs [2][COLS];
  logic [5:0] exp_pix [COLS];
  logic [3:0] exp_row;
  int wb = 0, count = 0, stream_start = -1000, oe_acc = 0;
  int checks = 0, errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_shift(input logic [5:0] d);
    if (count < COLS) bufs[wb][COLS-1-count] = d;
    if (count < 2*COLS) count++;
  endtask

  task automatic shift_px(input logic [5:0] d);
    {r1, g1, b1, r0, g0, b0} = d;
    tick(2);
    hub_clk = 1'b1;
    tick(3);
    hub_clk = 1'b0;
    tick(2);
    model_shift(d);
  endtask

  task automatic shift_random(input int n);
    for (int i = 0; i < n; i++) shift_px(6'($urandom));
  endtask

  task automatic oe_low(input int n);
    oe = 1'b0;
    tick(n);
    oe = 1'b1;
    tick(1);
    oe_acc += n;
  endtask

  task automatic do_latch(input string tag, input logic [3:0] r, input bit with_shift, input logic [5:0] d);
    bit busy;
    int exp_len, l0, o0, l8, o8;
    {rd, rc, rb, ra} = r;
    if (with_shift) {r1, g1, b1, r0, g0, b0} = d;
    tick(2);
    busy = (beat_n - stream_start) < COLS;
    if (with_shift) model_shift(d);
    exp_len = (count != COLS) ? 1 : 0;
    if (!busy) begin
      for (int c = 0; c < COLS; c++) exp_pix[c] = bufs[wb][c];
      exp_row = r;
      wb ^= 1;
      stream_start = beat_n;
    end
    count = 0;
    l0 = len_seen; o0 = ovf_seen; l8 = len8_seen; o8 = ovf8_seen;
    latch = 1'b1;
    if (with_shift) hub_clk = 1'b1;
    tick(3);
    latch = 1'b0;
    hub_clk = 1'b0;
    tick(3);
    check({tag, "_len_err"}, len_seen - l0, exp_len);
    check({tag, "_ovf"}, ovf_seen - o0, busy ? 1 : 0);
    check({tag, "_len_err8"}, len8_seen - l8, exp_len);
    check({tag, "_ovf8"}, ovf8_seen - o8, busy ? 1 : 0);
    check({tag, "_on_time"}, on_time, oe_acc);
    check({tag, "_on_time8"}, on_time8, (oe_acc > 255) ? 255 : oe_acc);
    oe_acc = 0;
  endtask

  task automatic check_stream(input string tag);
    logic [15:0] e;
    for (int i = 0; i < 3000 && beat_n < stream_start + COLS; i++) tick(1);
    check({tag, "_complete"}, (beat_n >= stream_start + COLS) ? 1 : 0, 1);
    if (beat_n >= stream_start + COLS) begin
      for (int c = 0; c < COLS; c++) begin
        e = {exp_pix[c], CW'(c), exp_row, (c == COLS-1) ? 1'b1 : 1'b0};
        check($sformatf("%s_beat%0d", tag, c), beat_mem[stream_start + c], e);
      end
    end
  endtask

  initial begin
    int v0, found;
    logic [5:0] d;
    rst_n = 1'b0; ready_fix = 1'b1; rnd_en = 1'b0;
    {r0, g0, b0, r1, g1, b1, ra, rb, rc, rd, hub_clk, latch} = '0;
    oe = 1'b1;
    tick(3);
    check("rst_valid", pif.valid, 0);
    check("rst_last", pif.last, 0);
    check("rst_rgb", pif.rgb, 0);
    check("rst_col", pif.col, 0);
    check("rst_row", pif.row, 0);
    check("rst_on_time", on_time, 0);
    check("rst_flags", {ovf, len_err}, 0);
    check("rst_valid8", pif8.valid, 0);
    rst_n = 1'b1;
    tick(4);

    for (int k = 0; k < COLS; k++) shift_px((k % 2 == 0) ? 6'b101010 : 6'b010101);
    v0 = valid_cyc;
    do_latch("t1", 4'd5, 1'b0, 6'd0);
    check_stream("t1");
    tick(2);
    check("t1_valid_cycles", valid_cyc - v0, COLS);
    check("t1_col0_rgb", beat_mem[stream_start][15:10], 6'b010101);
    shift_random(COLS);
    do_latch("t1b", 4'($urandom), 1'b0, 6'd0);
    check_stream("t1b");

    rnd_en = 1'b1;
    shift_random(30);
    do_latch("t2a", 4'($urandom), 1'b0, 6'd0);
    check_stream("t2a");
    shift_random(34);
    do_latch("t2b", 4'($urandom), 1'b0, 6'd0);
    check_stream("t2b");
    rnd_en = 1'b0;

    ready_fix = 1'b0;
    shift_random(COLS);
    do_latch("t3a", 4'd3, 1'b0, 6'd0);
    tick(100);
    check("t3_valid_held", pif.valid, 1);
    check("t3_col_held", pif.col, 0);
    shift_random(COLS);
    do_latch("t3b", 4'd7, 1'b0, 6'd0);
    ready_fix = 1'b1;
    check_stream("t3a");
    check("t3_stall_stable", stall_viol, 0);
    shift_random(COLS);
    do_latch("t3c", 4'($urandom), 1'b0, 6'd0);
    check_stream("t3c");

    oe_low(200);
    shift_random(COLS);
    do_latch("t4a", 4'($urandom), 1'b0, 6'd0);
    check_stream("t4a");
    oe_low(300);
    shift_random(COLS);
    do_latch("t4b", 4'($urandom), 1'b0, 6'd0);
    check_stream("t4b");
    oe_low($urandom_range(250, 1));
    shift_random(COLS);
    do_latch("t4c", 4'($urandom), 1'b0, 6'd0);
    check_stream("t4c");

    shift_random(COLS - 1);
    d = 6'($urandom);
    do_latch("t5", 4'($urandom), 1'b1, d);
    check_stream("t5");

    shift_random(COLS);
    {rd, rc, rb, ra} = 4'd9;
    tick(2);
    latch = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (pif.valid && pif.col == 5'd10) found = 1;
    end
    check("t6_reached_col10", found, 1);
    rst_n = 1'b0;
    #1;
    check("t6_valid_abort", pif.valid, 0);
    check("t6_col_abort", pif.col, 0);
    latch = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check("t6_valid_after", pif.valid, 0);
    check("t6_on_time_after", on_time, 0);
    count = 0; wb = 0; stream_start = -1000; oe_acc = 0;
    shift_random(COLS);
    do_latch("t6", 4'($urandom), 1'b0, 6'd0);
    check_stream("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
